// File: rtl/truth_table_checker.sv
// truth_table_checker
//   Walks every minterm of an N-input combinational function, holds each
//   stimulus for SETTLE cycles, samples the DUT output on the following
//   cycle and compares it with the expected truth-table bit EXPECT[stim].
//   At the end of a run it reports pass/fail, the number of failing minterms
//   and the lowest-indexed failing minterm.
//
// Ports
//   clk        in   1    single clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    begin a run (honoured in IDLE or DONE only)
//   dut_s      in   1    output of the device under test
//   stim       out  N    stimulus vector to the device (MSB = first input)
//   busy       out  1    high while a run is in progress
//   done       out  1    high once a run has finished, until the next start
//   pass       out  1    valid with done; 1 when no minterm failed
//   mismatch   out  1    one-cycle pulse after each failing sample
//   err_count  out  N+1  number of failing minterms
//   first_err  out  N    lowest failing minterm (valid when err_count != 0)
module truth_table_checker #(
  parameter int unsigned          N      = 2,
  parameter logic [(1<<N)-1:0]    EXPECT = 4'b1101,
  parameter int unsigned          SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         dut_s,
  output logic [N-1:0] stim,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         mismatch,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_err
);

  // Settle counter only has to count 0..SETTLE-1.
  localparam int unsigned     WW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WW-1:0]   WAIT_LAST = WW'(SETTLE - 1);
  localparam logic [WW-1:0]   WAIT_ZERO = {WW{1'b0}};
  localparam logic [WW-1:0]   WAIT_ONE  = WW'(1);
  localparam logic [N-1:0]    STIM_LAST = {N{1'b1}};
  localparam logic [N-1:0]    STIM_ZERO = {N{1'b0}};
  localparam logic [N-1:0]    STIM_ONE  = N'(1);
  localparam logic [N:0]      ERR_ZERO  = {(N+1){1'b0}};
  localparam logic [N:0]      ERR_ONE   = (N+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [N-1:0]    stim_q, stim_d;
  logic [N:0]      err_count_q, err_count_d;
  logic [N-1:0]    first_err_q, first_err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            mismatch_q, mismatch_d;
  logic            sample_fail_s;

  // State and result registers; reset clears every output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_q      <= WAIT_ZERO;
      stim_q      <= STIM_ZERO;
      err_count_q <= ERR_ZERO;
      first_err_q <= STIM_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stim_q      <= stim_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      mismatch_q  <= mismatch_d;
    end
  end

  // Next-state logic: start is only looked at when no run is active.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_DRIVE;
        else       state_d = ST_IDLE;
      end
      ST_DRIVE: begin
        if (wait_q == WAIT_LAST) state_d = ST_SAMPLE;
        else                     state_d = ST_DRIVE;
      end
      ST_SAMPLE: begin
        // The last minterm always ends the run; stim never wraps.
        if (stim_q == STIM_LAST) state_d = ST_DONE;
        else                     state_d = ST_DRIVE;
      end
      ST_DONE: begin
        if (start) state_d = ST_DRIVE;
        else       state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output values for the next cycle.
  always_comb begin
    sample_fail_s = (state_q == ST_SAMPLE) && (dut_s != EXPECT[stim_q]);
    wait_d        = wait_q;
    stim_d        = stim_q;
    err_count_d   = err_count_q;
    first_err_d   = first_err_q;
    mismatch_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // A new run starts from a clean slate.
          wait_d      = WAIT_ZERO;
          stim_d      = STIM_ZERO;
          err_count_d = ERR_ZERO;
          first_err_d = STIM_ZERO;
        end else begin
          wait_d      = wait_q;
          stim_d      = stim_q;
        end
      end
      ST_DRIVE: begin
        wait_d = wait_q + WAIT_ONE;
      end
      ST_SAMPLE: begin
        if (sample_fail_s) begin
          err_count_d = err_count_q + ERR_ONE;
          mismatch_d  = 1'b1;
          // Minterms are walked in ascending order, so the first failure
          // of the run is also the lowest-indexed one.
          if (err_count_q == ERR_ZERO) first_err_d = stim_q;
          else                         first_err_d = first_err_q;
        end else begin
          err_count_d = err_count_q;
        end
        if (stim_q != STIM_LAST) begin
          stim_d = stim_q + STIM_ONE;
          wait_d = WAIT_ZERO;
        end else begin
          stim_d = stim_q;
        end
      end
      default: begin
        wait_d = WAIT_ZERO;
      end
    endcase
    // Status flags follow the state being entered so they line up with it.
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
    pass_d = (state_d == ST_DONE) && (err_count_d == ERR_ZERO);
  end

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_count_q;
  assign first_err = first_err_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker: one N=2/SETTLE=1 instance and
// one N=3/SETTLE=3 instance, each driven by an emulated DUT given as a truth
// table. Expected traces come from a minterm-level model of a check run.
module tb_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic       sel;        // 0: N=2 instance, 1: N=3 instance
  logic [7:0] tbl;        // emulated DUT truth table, bit m = output for stim m
  logic       noise_bit;  // glitch injected on dut_s outside sample cycles

  logic       start2, dut2_s, busy2, done2, pass2, mis2;
  logic [1:0] stim2, first2;
  logic [2:0] err2;
  logic       start3, dut3_s, busy3, done3, pass3, mis3;
  logic [2:0] stim3, first3;
  logic [3:0] err3;

  assign start2 = start & ~sel;
  assign start3 = start & sel;
  assign dut2_s = tbl[{1'b0, stim2}] ^ noise_bit;
  assign dut3_s = tbl[stim3] ^ noise_bit;

  truth_table_checker #(.N(2), .EXPECT(4'b1101), .SETTLE(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_s(dut2_s),
    .stim(stim2), .busy(busy2), .done(done2), .pass(pass2),
    .mismatch(mis2), .err_count(err2), .first_err(first2)
  );

  truth_table_checker #(.N(3), .EXPECT(8'b10010110), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .dut_s(dut3_s),
    .stim(stim3), .busy(busy3), .done(done3), .pass(pass3),
    .mismatch(mis3), .err_count(err3), .first_err(first3)
  );

  logic       obs_busy, obs_done, obs_pass, obs_mis;
  logic [2:0] obs_stim, obs_first;
  logic [3:0] obs_err;
  logic [9:0] obs_word;

  always_comb begin
    if (sel) begin
      obs_busy = busy3; obs_done = done3; obs_pass = pass3; obs_mis = mis3;
      obs_stim = stim3; obs_first = first3; obs_err = err3;
    end else begin
      obs_busy = busy2; obs_done = done2; obs_pass = pass2; obs_mis = mis2;
      obs_stim = {1'b0, stim2}; obs_first = {1'b0, first2}; obs_err = {1'b0, err2};
    end
    obs_word = {obs_busy, obs_done, obs_mis, obs_stim, obs_err};
  end

  int compared = 0;
  int failed   = 0;

  logic [9:0] obs_tr[$];
  logic [9:0] exp_tr[$];
  int         exp_errs;
  int         exp_first;
  bit         exp_pass;

  // Reference: per cycle after the start edge, {busy,done,mismatch,stim,err}.
  function automatic void build_expect(input int n, input int s, input logic [7:0] mask);
    int nm, total, errs, m, st;
    bit smp, fnow, b, d;
    nm = 1 << n; total = nm * (s + 1); errs = 0;
    exp_first = 0; exp_tr.delete();
    for (int j = 0; j <= total; j++) begin
      m   = j / (s + 1);
      smp = (j > 0) && (j % (s + 1) == 0);
      fnow = 1'b0;
      if (smp) fnow = (tbl[m-1] != mask[m-1]);
      if (fnow) begin
        if (errs == 0) exp_first = m - 1;
        errs++;
      end
      b  = (j < total);
      d  = (j == total);
      st = (j < total) ? m : nm - 1;
      exp_tr.push_back({b, d, fnow, 3'(st), 4'(errs)});
    end
    exp_errs = errs;
    exp_pass = (errs == 0);
  endfunction

  // Pulse (or hold) start and record one observation per cycle of the run.
  task automatic do_run(input bit hold, input bit use_noise);
    int s, total;
    s = sel ? 3 : 1;
    total = (sel ? 8 : 4) * (s + 1);
    obs_tr.delete();
    @(negedge clk); start = 1'b1; noise_bit = 1'b0;
    @(posedge clk); #1; obs_tr.push_back(obs_word);
    for (int j = 1; j <= total; j++) begin
      @(negedge clk);
      start = hold;
      noise_bit = (use_noise && (j % (s + 1) != 0)) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1; obs_tr.push_back(obs_word);
    end
    @(negedge clk); noise_bit = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; tbl = 8'h00; noise_bit = 1'b0;
    #3;
    for (int i = 0; i < 2; i++) begin
      sel = 1'(i); #1;
      compared++;
      if ({obs_word, obs_pass, obs_first} !== 14'd0) begin
        failed++;
        $display("FAIL reset_values sel=%0d: got %h want 0000", i, {obs_word, obs_pass, obs_first});
      end
    end
    @(negedge clk); rst_n = 1'b1; sel = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all_pass();
    sel = 1'b0; tbl = 8'b0000_1101;   // a | ~b with stim = {a,b}
    build_expect(2, 1, 8'b0000_1101);
    do_run(1'b0, 1'b0);
    foreach (exp_tr[i]) begin
      compared++;
      if (obs_tr[i] !== exp_tr[i]) begin
        failed++; $display("FAIL pass_trace cyc %0d: got %h want %h", i, obs_tr[i], exp_tr[i]);
      end
    end
    compared++;
    if (obs_pass !== 1'b1) begin failed++; $display("FAIL pass_flag: got %b want 1", obs_pass); end
  endtask

  task automatic test_all_fail();
    sel = 1'b0; tbl = 8'b0000_0010;   // ~a & b
    build_expect(2, 1, 8'b0000_1101);
    do_run(1'b0, 1'b0);
    foreach (exp_tr[i]) begin
      compared++;
      if (obs_tr[i] !== exp_tr[i]) begin
        failed++; $display("FAIL allfail_trace cyc %0d: got %h want %h", i, obs_tr[i], exp_tr[i]);
      end
    end
    compared++;
    if ({obs_pass, obs_err, obs_first} !== {1'b0, 4'd4, 3'd0}) begin
      failed++; $display("FAIL allfail_result: got %b/%0d/%0d want 0/4/0", obs_pass, obs_err, obs_first);
    end
  endtask

  task automatic test_stuck_one();
    sel = 1'b0; tbl = 8'b0000_1111;
    build_expect(2, 1, 8'b0000_1101);
    do_run(1'b0, 1'b0);
    foreach (exp_tr[i]) begin
      compared++;
      if (obs_tr[i] !== exp_tr[i]) begin
        failed++; $display("FAIL stuck_trace cyc %0d: got %h want %h", i, obs_tr[i], exp_tr[i]);
      end
    end
    compared++;
    if ({obs_pass, obs_err, obs_first} !== {1'b0, 4'd1, 3'd1}) begin
      failed++; $display("FAIL stuck_result: got %b/%0d/%0d want 0/1/1", obs_pass, obs_err, obs_first);
    end
  endtask

  task automatic test_mid_run_reset();
    bit hit;
    sel = 1'b0; tbl = 8'b0000_1111;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(posedge clk); #1;
      if (obs_stim == 3'd2) hit = 1'b1;
    end
    compared++;
    if (!hit) begin failed++; $display("FAIL reach_stim2: got stim %0d want 2", obs_stim); end
    @(negedge clk); #2; rst_n = 1'b0; #1;
    compared++;
    if ({obs_word, obs_pass, obs_first} !== 14'd0) begin
      failed++; $display("FAIL async_reset: got %h want 0000", {obs_word, obs_pass, obs_first});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    compared++;
    if ({obs_word, obs_pass} !== 11'd0) begin
      failed++; $display("FAIL idle_after_reset: got %h want 000", {obs_word, obs_pass});
    end
    tbl = 8'b0000_1101;
    build_expect(2, 1, 8'b0000_1101);
    do_run(1'b0, 1'b0);
    foreach (exp_tr[i]) begin
      compared++;
      if (obs_tr[i] !== exp_tr[i]) begin
        failed++; $display("FAIL rerun_trace cyc %0d: got %h want %h", i, obs_tr[i], exp_tr[i]);
      end
    end
  endtask

  task automatic test_start_held();
    bit hit;
    sel = 1'b0; tbl = 8'b0000_1111;
    build_expect(2, 1, 8'b0000_1101);
    do_run(1'b1, 1'b0);               // start stays high for the whole run
    foreach (exp_tr[i]) begin
      compared++;
      if (obs_tr[i] !== exp_tr[i]) begin
        failed++; $display("FAIL held_trace cyc %0d: got %h want %h", i, obs_tr[i], exp_tr[i]);
      end
    end
    // Still in DONE with start high: the next edge restarts and clears.
    @(posedge clk); #1;
    compared++;
    if (obs_word !== 10'b10_0_000_0000) begin
      failed++; $display("FAIL restart_from_done: got %h want %h", obs_word, 10'b10_0_000_0000);
    end
    @(negedge clk); start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(posedge clk); #1;
      if (obs_done) hit = 1'b1;
    end
    compared++;
    if (!hit) begin failed++; $display("FAIL restart_done_timeout: got done 0 want 1"); end
  endtask

  task automatic test_xor3();
    logic [2:0] mv;
    sel = 1'b1;
    for (int x = 0; x < 2; x++) begin
      for (int m = 0; m < 8; m++) begin
        mv = 3'(m);
        tbl[m] = (^mv) ^ x[0];        // x=0: XOR3, x=1: XNOR3
      end
      build_expect(3, 3, 8'b1001_0110);
      do_run(1'b0, 1'b0);
      foreach (exp_tr[i]) begin
        compared++;
        if (obs_tr[i] !== exp_tr[i]) begin
          failed++; $display("FAIL xor3_trace x=%0d cyc %0d: got %h want %h", x, i, obs_tr[i], exp_tr[i]);
        end
      end
      compared++;
      if ({obs_pass, obs_err, obs_first} !== {(x == 0), (x == 0) ? 4'd0 : 4'd8, 3'd0}) begin
        failed++; $display("FAIL xor3_result x=%0d: got %b/%0d/%0d", x, obs_pass, obs_err, obs_first);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      sel = 1'(it % 2);
      tbl = 8'($urandom);
      if (sel) build_expect(3, 3, 8'b1001_0110);
      else     build_expect(2, 1, 8'b0000_1101);
      do_run(1'b0, 1'b1);             // glitches outside sample cycles must not matter
      foreach (exp_tr[i]) begin
        compared++;
        if (obs_tr[i] !== exp_tr[i]) begin
          failed++; $display("FAIL rand_trace it=%0d cyc %0d: got %h want %h", it, i, obs_tr[i], exp_tr[i]);
        end
      end
      compared++;
      if (obs_pass !== exp_pass) begin
        failed++; $display("FAIL rand_pass it=%0d: got %b want %b", it, obs_pass, exp_pass);
      end
      if (exp_errs != 0) begin
        compared++;
        if (obs_first !== 3'(exp_first)) begin
          failed++; $display("FAIL rand_first it=%0d: got %0d want %0d", it, obs_first, exp_first);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_all_fail();
    test_stuck_one();
    test_mid_run_reset();
    test_start_held();
    test_xor3();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Sequential response checker for the combinational exercise modules. It walks every minterm of an N-input function and drives each one onto the device under test. It samples the single-bit DUT output after a configurable settle time and compares it against an expected truth-table mask. At the end it reports pass/fail, the mismatch count and the first failing minterm, so a module can be self-checked in hardware instead of by reading printed truth tables.

## Interface
Parameters:
- N, default 2 — number of DUT inputs (1..8).
- EXPECT, default 4'b1101 — expected output per minterm, 2^N bits; bit m = expected s for stimulus m. The default encodes s = a | ~b with stim = {a,b}.
- SETTLE, default 1 — cycles each stimulus is held before sampling (>= 1).

Ports:
- clk  in  1 — single clock; all state changes on rising edge.
- rst_n  in  1 — reset, asynchronous, active-low.
- start  in  1 — begin a check run; sampled in IDLE or DONE only.
- dut_s  in  1 — DUT output under test.
- stim  out  N — stimulus vector to DUT inputs (MSB = first input).
- busy  out  1 — high in DRIVE/SAMPLE.
- done  out  1 — high in DONE; held until next start.
- pass  out  1 — valid while done; 1 iff err_count == 0.
- mismatch  out  1 — one-cycle pulse on the cycle after a failing sample.
- err_count  out  N+1 — number of failing minterms (saturates at 2^N by construction).
- first_err  out  N — lowest-indexed failing minterm; valid when err_count != 0.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: stim=0, counters idle. On start=1 → DRIVE. Entering DRIVE:
  - stim=0, wait=0
  - err_count=0
  - first_err=0
  - mismatch=0
- DRIVE: stim held; wait increments each cycle. After SETTLE cycles in DRIVE → SAMPLE.
- SAMPLE: one cycle. At the closing edge, compare dut_s with EXPECT[stim].
  - On a difference: err_count += 1, and mismatch=1 for the next cycle.
  - If the difference is the first of the run: first_err=stim.
  - Then, if stim == 2^N−1 → DONE; else stim += 1, wait=0 → DRIVE.
- DONE: done=1; pass = (err_count==0); stim holds last value; results held. start=1 → restart exactly as from IDLE, clearing results.
- start while busy: ignored; the run is not restarted or extended.
- rst_n low at any time (including mid-run) forces IDLE immediately and clears all outputs to reset values. Results of the aborted run are lost.
- stim counter does not wrap within a run; the last minterm always terminates the run.

## Timing
- Reset values: stim=0, busy=0, done=0, pass=0, mismatch=0, err_count=0, first_err=0.
- Per minterm: SETTLE+1 cycles (SETTLE in DRIVE, 1 in SAMPLE).
- Latency: start sampled at edge k gives busy=1 from k, and done=1 from edge k + 2^N·(SETTLE+1).
- stim changes only on the edge leaving SAMPLE. The DUT sees each value stable for SETTLE+1 cycles.
- dut_s is sampled only at the SAMPLE-closing edge. Changes at other times have no effect.
- mismatch and the err_count update appear on the same edge. pass and done rise together.

## Test plan
1. N=2, SETTLE=1, DUT = a|~b, pulse start → done=1 exactly 8 cycles later; pass=1; err_count=0; mismatch never high; stim sequence 0,1,2,3 with each held 2 cycles.
2. Same bench, DUT = ~a&b (outputs 0,1,0,0) → err_count=4, first_err=2'b00, pass=0, four mismatch pulses.
3. DUT stuck at 1 → single mismatch at minterm 1: err_count=1, first_err=2'b01, pass=0.
4. Assert rst_n=0 while stim=2 mid-run → outputs return to reset values asynchronously, before the next edge. After release, the FSM idles until start; a new start runs a full clean pass.
5. start held high throughout a run → no restart while busy. In DONE, start restarts: err_count clears and done drops on the next edge.
6. N=3, SETTLE=3, EXPECT=8'b10010110 (XOR3), XOR DUT → done 32 cycles after start, pass=1. Swap in an XNOR DUT → err_count=8, first_err=3'b000.
